// File: rtl/ldpc_pkg.sv
// Shared QC-LDPC helpers: zero-block marker, matrix/block slicing and shift scaling.
package ldpc_pkg;

  // Base-matrix entry value that marks an all-zero circulant.
  localparam int NEG = -1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_P0,
    S_PAR,
    S_DONE
  } enc_state_e;

  // LSB of entry (r,c) in a row-major packed matrix, entry (0,0) at the top.
  function automatic int entry_lsb(int r, int c, int rows, int cols, int w);
    return (rows * cols - 1 - (r * cols + c)) * w;
  endfunction

  // LSB of block j in a vector of nblk blocks, block 0 at the top.
  function automatic int blk_lsb(int j, int nblk, int d);
    return (nblk - 1 - j) * d;
  endfunction

  // Rescale a shift written against lift z0 to lift d.
  function automatic int scale_shift(int s, int d, int z0);
    return (s * d) / z0;
  endfunction

endpackage

// File: rtl/qc_rotate.sv
// D-bit circulant rotator: bit k of y takes bit (k+sh) mod D of x, where
// bit k of a block lives at vector index D-1-k. zero forces an all-zero block.
module qc_rotate #(
  parameter int D  = 24,
  parameter int SW = 5
) (
  input  logic [D-1:0]  x,
  input  logic [SW-1:0] sh,
  input  logic          zero,
  output logic [D-1:0]  y
);

  logic [D-1:0] xr;
  logic [D-1:0] yr;
  logic [SW:0]  idx;

  // Work in bit-number order so the rotation is a plain indexed pick.
  always_comb begin
    xr  = '0;
    yr  = '0;
    idx = '0;
    y   = '0;
    for (int k = 0; k < D; k++) xr[k] = x[D-1-k];
    for (int k = 0; k < D; k++) begin
      idx = (SW+1)'(k) + {1'b0, sh};
      if (idx >= (SW+1)'(D)) idx = idx - (SW+1)'(D);
      yr[k] = xr[idx[SW-1:0]];
    end
    for (int k = 0; k < D; k++) y[D-1-k] = zero ? 1'b0 : yr[k];
  end

endmodule

// File: rtl/ldpc_enc.sv
// Systematic QC-LDPC encoder with dual-diagonal parity: C cycles of row
// accumulation, one cycle for p0, C-1 cycles of staircase back-substitution.
module ldpc_enc
  import ldpc_pkg::*;
#(
  parameter int C      = 12,
  parameter int R      = 24,
  parameter int D      = 24,
  parameter int data_w = 8,
  parameter int Z0     = 96
) (
  input  logic                    en,
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(R-C)*D-1:0]      u,
  input  logic [C*R*data_w-1:0]   m,
  output logic [R*D-1:0]          cw,
  output logic [1:0]              status
);

  localparam int K    = R - C;
  localparam int SW   = (D > 1) ? $clog2(D) : 1;
  localparam int CNTW = (C > 1) ? $clog2(C) : 1;
  localparam int MW   = $clog2(C*R*data_w);

  enc_state_e                state_q, state_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [K*D-1:0]            u_q, u_d;
  logic [C*R*data_w-1:0]     m_q, m_d;
  logic [C-1:0][D-1:0]       lam_q, lam_d;
  logic [C-1:0][D-1:0]       p_q, p_d;
  logic [D-1:0]              sig_q, sig_d;
  logic [R*D-1:0]            cw_q, cw_d;
  logic                      done_q, done_d;

  logic [K:0][SW-1:0]        sh;
  logic [K:0]                zr;
  logic signed [data_w-1:0]  ev;
  logic [MW-1:0]             lsb;
  logic [K-1:0][D-1:0]       rot_y;
  logic [D-1:0]              rot_p0;
  logic [D-1:0]              lam_now;
  logic [D-1:0]              par;

  // Scaled shifts of row cnt for columns 0..K; negative entries are zero blocks.
  always_comb begin
    sh  = '0;
    zr  = '0;
    ev  = '0;
    lsb = '0;
    for (int c = 0; c <= K; c++) begin
      lsb   = MW'(entry_lsb(int'(cnt_q), c, C, R, data_w));
      ev    = m_q[lsb +: data_w];
      zr[c] = (int'(ev) <= NEG);
      sh[c] = zr[c] ? '0 : SW'(scale_shift(int'(ev), D, Z0) % D);
    end
  end

  for (genvar c = 0; c < K; c++) begin : g_rot
    qc_rotate #(.D(D), .SW(SW)) u_rot (
      .x    (u_q[blk_lsb(c, K, D) +: D]),
      .sh   (sh[c]),
      .zero (zr[c]),
      .y    (rot_y[c])
    );
  end

  qc_rotate #(.D(D), .SW(SW)) u_rot_p0 (
    .x    (p_q[0]),
    .sh   (sh[K]),
    .zero (zr[K]),
    .y    (rot_p0)
  );

  // Row syndrome of the information part for the current row.
  always_comb begin
    lam_now = '0;
    for (int c = 0; c < K; c++) lam_now = lam_now ^ rot_y[c];
  end

  // Next-state, datapath updates and codeword assembly on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    m_d     = m_q;
    lam_d   = lam_q;
    p_d     = p_q;
    sig_d   = sig_q;
    cw_d    = cw_q;
    done_d  = done_q;
    // Row 0 of the staircase has no previous parity block.
    par     = lam_q[cnt_q] ^ rot_p0 ^ ((cnt_q == '0) ? '0 : p_q[cnt_q]);
    case (state_q)
      S_IDLE: if (start) begin
        u_d     = u;
        m_d     = m;
        sig_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        lam_d[cnt_q] = lam_now;
        sig_d        = sig_q ^ lam_now;
        if (cnt_q == CNTW'(C-1)) begin
          cnt_d   = '0;
          state_d = S_P0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_P0: begin
        // Column-K end entries cancel, so the sum of all row syndromes is p0.
        p_d[0]  = sig_q;
        cnt_d   = '0;
        state_d = (C == 1) ? S_DONE : S_PAR;
      end
      S_PAR: begin
        p_d[cnt_q + 1'b1] = par;
        if (cnt_q == CNTW'(C-2)) state_d = S_DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) begin
      cw_d[R*D-1 -: K*D] = u_q;
      for (int i = 0; i < C; i++) cw_d[blk_lsb(K+i, R, D) +: D] = p_d[i];
      done_d = 1'b1;
    end
  end

  // State registers; en low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      m_q     <= '0;
      lam_q   <= '0;
      p_q     <= '0;
      sig_q   <= '0;
      cw_q    <= '0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      m_q     <= m_d;
      lam_q   <= lam_d;
      p_q     <= p_d;
      sig_q   <= sig_d;
      cw_q    <= cw_d;
      done_q  <= done_d;
    end
  end

  assign cw     = cw_q;
  assign status = {(state_q == S_ACCUM) || (state_q == S_P0) || (state_q == S_PAR), done_q};

endmodule

// File: tb/tb_ldpc_enc.sv
// Self-checking bench for ldpc_enc: vector table, random blocks against a
// bit-level parity model, full-matrix syndrome check, and control corner cases.
module tb_ldpc_enc;
  localparam int C = 12, R = 24, D = 24, W = 8, Z0 = 96;
  localparam int K = R - C, KD = K * D, RD = R * D;

  logic              clk = 1'b0;
  logic              rst, en, start;
  logic [KD-1:0]     u;
  logic [C*R*W-1:0]  m;
  logic [RD-1:0]     cw;
  logic [1:0]        status;

  int checks = 0, failures = 0;
  int hm[C][R];

  // Information columns plus column K of a dual-diagonal rate-1/2 matrix (Z0=96).
  int info[C][K+1] = '{
    '{-1,94,73,-1,-1,-1,-1,-1,55,83,-1,-1, 7},
    '{-1,27,-1,-1,-1,22,79, 9,-1,-1,-1,12,-1},
    '{-1,-1,-1,24,22,81,-1,33,-1,-1,-1, 0,-1},
    '{61,-1,47,-1,-1,-1,-1,-1,65,25,-1,-1,-1},
    '{-1,-1,39,-1,-1,-1,84,-1,-1,41,72,-1,-1},
    '{-1,-1,-1,-1,46,40,-1,82,-1,-1,-1,79, 0},
    '{-1,-1,95,53,-1,-1,-1,-1,-1,14,18,-1,-1},
    '{-1,11,73,-1,-1,-1, 2,-1,-1,47,-1,-1,-1},
    '{12,-1,-1,-1,83,24,-1,43,-1,-1,-1,51,-1},
    '{-1,-1,-1,-1,-1,94,-1,59,-1,-1,70,72,-1},
    '{-1,-1, 7,65,-1,-1,-1,-1,39,49,-1,-1,-1},
    '{43,-1,-1,-1,-1,66,-1,41,-1,-1,-1,26, 7}
  };

  typedef struct {
    logic [KD-1:0] u;
    int            gap;
    int            exp_lat;
    int            exp_busy;
  } vec_t;
  vec_t vt[6];

  ldpc_enc #(.C(C), .R(R), .D(D), .data_w(W), .Z0(Z0)) dut (
    .en(en), .clk(clk), .rst(rst), .start(start),
    .u(u), .m(m), .cw(cw), .status(status)
  );

  always #5 clk = ~clk;

  function automatic int sc(int s);
    return s * D / Z0;
  endfunction

  function automatic logic [KD-1:0] rand_u();
    logic [KD-1:0] r;
    r = '0;
    for (int i = 0; i < KD / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Parity from the encoding rules, bit-numbered (bit k of a block at offset D-1-k).
  function automatic logic [RD-1:0] model_cw(logic [KD-1:0] uu);
    bit ub[K][D];
    bit lam[C][D];
    bit p[C][D];
    logic [RD-1:0] r;
    for (int c = 0; c < K; c++)
      for (int k = 0; k < D; k++) ub[c][k] = uu[(K-1-c)*D + D-1-k];
    for (int i = 0; i < C; i++)
      for (int k = 0; k < D; k++) begin
        lam[i][k] = 0;
        for (int c = 0; c < K; c++)
          if (hm[i][c] >= 0) lam[i][k] ^= ub[c][(k + sc(hm[i][c])) % D];
      end
    for (int k = 0; k < D; k++) begin
      p[0][k] = 0;
      for (int i = 0; i < C; i++) p[0][k] ^= lam[i][k];
    end
    for (int i = 0; i < C - 1; i++)
      for (int k = 0; k < D; k++) begin
        p[i+1][k] = lam[i][k] ^ ((i > 0) ? p[i][k] : 1'b0);
        if (hm[i][K] >= 0) p[i+1][k] ^= p[0][(k + sc(hm[i][K])) % D];
      end
    r = '0;
    r[RD-1 -: KD] = uu;
    for (int i = 0; i < C; i++)
      for (int k = 0; k < D; k++) r[(C-1-i)*D + D-1-k] = p[i][k];
    return r;
  endfunction

  // Weight of H*x over the full matrix, staircase columns included.
  function automatic int syndrome_wt(logic [RD-1:0] x);
    int wt;
    bit s;
    wt = 0;
    for (int i = 0; i < C; i++)
      for (int k = 0; k < D; k++) begin
        s = 0;
        for (int c = 0; c < R; c++)
          if (hm[i][c] >= 0) s ^= x[(R-1-c)*D + D-1-((k + sc(hm[i][c])) % D)];
        wt += int'(s);
      end
    return wt;
  endfunction

  task automatic chk(input string nm, input logic [RD-1:0] act, input logic [RD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Start a block, optionally drop en for gap cycles and pulse start mid-block;
  // returns edges from the start edge to done, and busy cycles seen.
  task automatic run_block(input logic [KD-1:0] uu, input int gap, input int pulse_at,
                           output int lat, output int busy_n, output logic [RD-1:0] got);
    @(negedge clk);
    u = uu;
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_n = 0;
    @(negedge clk);
    start = 1'b0;
    u = rand_u();
    while (!status[0] && lat < 200) begin
      if (status[1]) busy_n++;
      en = !(gap > 0 && lat >= 3 && lat < 3 + gap);
      start = (pulse_at > 0 && lat == pulse_at);
      if (start) u = rand_u();
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    en = 1'b1;
    start = 1'b0;
    got = cw;
    if (!status[0]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done want done within 200 cycles");
    end
  endtask

  initial begin
    int lat, busy_n, idle_busy;
    logic [RD-1:0] got;
    logic [KD-1:0] ux;

    for (int r = 0; r < C; r++)
      for (int c = 0; c < R; c++)
        if (c <= K) hm[r][c] = info[r][c];
        else        hm[r][c] = (r == c - K - 1 || r == c - K) ? 0 : -1;
    m = '0;
    for (int r = 0; r < C; r++)
      for (int c = 0; c < R; c++) m[(C*R-1-(r*R+c))*W +: W] = W'(hm[r][c]);

    rst = 1'b0; en = 1'b1; start = 1'b0; u = '0;
    #12;
    chk("reset_cw", cw, '0);
    chk_i("reset_status", int'(status), 0);
    @(negedge clk);
    rst = 1'b1;

    vt[0] = '{u: '0, gap: 0, exp_lat: 25, exp_busy: 24};
    ux = '0; ux[KD-1] = 1'b1;
    vt[1] = '{u: ux, gap: 0, exp_lat: 25, exp_busy: 24};
    vt[2] = '{u: '1, gap: 0, exp_lat: 25, exp_busy: 24};
    vt[3] = '{u: {9{32'hA5A5_0F0F}}, gap: 0, exp_lat: 25, exp_busy: 24};
    ux = rand_u();
    vt[4] = '{u: ux, gap: 7, exp_lat: 32, exp_busy: 31};
    vt[5] = '{u: ux, gap: 0, exp_lat: 25, exp_busy: 24};

    for (int i = 0; i < 6; i++) begin
      run_block(vt[i].u, vt[i].gap, 0, lat, busy_n, got);
      chk_i($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk_i($sformatf("vec%0d_busy_cycles", i), busy_n, vt[i].exp_busy);
      chk($sformatf("vec%0d_cw", i), got, model_cw(vt[i].u));
      chk_i($sformatf("vec%0d_syndrome", i), syndrome_wt(got), 0);
      chk($sformatf("vec%0d_systematic", i), {{KD{1'b0}}, got[RD-1 -: KD]}, {{KD{1'b0}}, vt[i].u});
      @(posedge clk);
      @(negedge clk);
      chk_i($sformatf("vec%0d_status_after", i), int'(status), 1);
    end
    chk("zero_u_zero_cw", model_cw('0), '0);

    for (int n = 0; n < 50; n++) begin
      ux = rand_u();
      run_block(ux, 0, 0, lat, busy_n, got);
      chk_i($sformatf("rand%0d_latency", n), lat, 25);
      chk($sformatf("rand%0d_cw", n), got, model_cw(ux));
      chk_i($sformatf("rand%0d_syndrome", n), syndrome_wt(got), 0);
    end

    // start coinciding with en low is never sampled
    @(negedge clk);
    start = 1'b1; en = 1'b0;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    @(negedge clk);
    chk_i("start_en_low_lost", int'(status), 1);

    // start pulse while busy is ignored; u changes after acceptance don't matter
    ux = rand_u();
    run_block(ux, 0, 5, lat, busy_n, got);
    chk_i("busy_start_latency", lat, 25);
    chk("busy_start_cw", got, model_cw(ux));
    idle_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (status != 2'b01) idle_busy++;
    end
    chk_i("busy_start_single_done", idle_busy, 0);

    // asynchronous reset mid-block, then a clean restart
    @(negedge clk);
    u = rand_u(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_cw", cw, '0);
    chk_i("midreset_status", int'(status), 0);
    @(negedge clk);
    rst = 1'b1;
    ux = rand_u();
    run_block(ux, 0, 0, lat, busy_n, got);
    chk_i("after_reset_latency", lat, 25);
    chk("after_reset_cw", got, model_cw(ux));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_enc.md
# ldpc_enc

Systematic quasi-cyclic LDPC encoder, the transmit-side counterpart of `ldpc_core`. It uses the same base-matrix format and the same bit packing, so a codeword produced here decodes in `ldpc_core` without any reformatting. Default configuration is WiMax rate 1/2: a 12×24 base matrix with lift D=24, giving 288 information bits in and a 576-bit codeword out. Parity is computed over a fixed number of cycles using the dual-diagonal parity structure.

## Interface
Parameters:
- `C`, 12: base-matrix rows, which is also the number of parity blocks.
- `R`, 24: base-matrix columns; K=R-C information blocks.
- `D`, 24: lift (circulant) size.
- `data_w`, 8: width of each base-matrix entry, signed.
- `Z0`, 96: native lift against which the shift entries are expressed.

Ports:
- `en` in 1: clock enable; when low, all state and outputs hold.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin encoding; sampled only in IDLE with `en`=1.
- `u` in K*D: information bits.
- `m` in C*R*data_w: base matrix. Entry (r,c) is at `[(C*R-1-(r*R+c))*data_w +: data_w]`; the value -1 marks a zero block.
- `cw` out R*D: codeword. Block j is at `[(R-1-j)*D +: D]`. Blocks 0..K-1 are `u` unchanged; blocks K..R-1 are parity p0..p(C-1).
- `status` out 2: bit 0 = done (level), bit 1 = busy.

## Operation
- Effective shift of entry s≥0: s' = floor(s*D/Z0). This is identical to the `ldpc_core` scaling.
- rot(x,s'): output bit k = x[(k+s') mod D]. Bit k of a block is at block offset D-1-k.
- `u` and `m` are registered when `start` is accepted. Later changes to the inputs have no effect on the current block.
- States and transitions:
  - **IDLE**: wait for `start`.
  - **ACCUM**: C cycles. On cycle i, λ_i = XOR over c<K of rot(u_c, s'(i,c)). λ_i is stored, and Σ ^= λ_i.
  - **P0**: 1 cycle. p0 = Σ. This relies on the two nonzero end entries of column K having equal shifts, so their contributions cancel.
  - **PAR**: C-1 cycles. p1 = λ_0 ^ rot(p0, s'(0,K)). After that, p(i+1) = p_i ^ λ_i ^ rot(p0, s'(i,K)), where the rot term is zero when the entry is -1.
  - **DONE**: return to IDLE.
- `cw` updates only when the block reaches DONE, and it holds until the next completion.
- done (`status[0]`) rises on the DONE cycle and stays high until the next accepted `start`. busy (`status[1]`) is high in ACCUM, P0 and PAR.
- `start` while busy is ignored. There is no queuing.
- Entries of -1 in columns ≥K+1 are never read. Only column K is used for parity; the staircase columns are implied.
- The block does not check the matrix. If `m` does not have the dual-diagonal structure, `cw` is undefined, but the cycle count is unchanged.

## Timing
- Reset (`rst`=0, asynchronous): state goes to IDLE; `cw`=0; `status`=2'b00; λ, Σ and the parity registers are cleared. A reset in mid-operation aborts the block, and no done is produced.
- Cycle n: `start`=1 is sampled.
- Cycle n+1: busy=1.
- Cycle n+2C+1: DONE; `cw` is valid and done=1.
- Cycle n+2C+2: busy=0.
- Latency with `en` held high is 2C+1 = 25 cycles. Each cycle with `en`=0 adds exactly one cycle.
- A new `start` is accepted on the cycle after DONE at the earliest. The sustained rate is one block per 2C+2 cycles.
- A `start` that coincides with an `en` low is lost, because it is not sampled.

## Structure
- Shared package `ldpc_pkg`, also used by `ldpc_core`, holds:
  - the `NEG` (-1) entry constant;
  - functions for entry extraction and block slicing;
  - the shift-scaling function floor(s*D/Z0).
- Sub-module `qc_rotate`: a D-bit barrel rotator with a zero-block bypass. There are K+1 instances: K for ACCUM and one for the p0 term.

## Test plan
- `u`=0 with the WiMax 1/2 `m` → `cw`=0; done at start+25; busy high for exactly 24 cycles.
- `u` with only bit 0 of block 0 set → `cw` satisfies H·cw=0 against the golden model, and bits 0..287 equal `u`.
- 50 random `u` vectors, looped back: map bit 0→+20 and bit 1→-20, feed to `ldpc_core` → `s` equals `cw` and the core reports success.
- `en` low for 7 cycles during ACCUM → done at start+32, with `cw` identical to the run with `en` held high.
- `rst` pulled low at start+10, then a restart → `cw`=0 and `status`=0 immediately; the next block completes correctly after a further 25 cycles.
- `start` pulsed at start+5 while busy → ignored. Only one done is produced, and `cw` matches the first `u` even though `u` changed after acceptance.
